seg_scan_controller: RTL

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

---
 rtl/seg_scan_controller.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_controller.sv
// ============================================================================
// seg_scan_controller
// ----------------------------------------------------------------------------
// Time-multiplexed driver for a 4-digit, common-anode 7-segment display.
//
// Each digit gets a scan slot of DEAD_CYCLES all-dark cycles, which stop the
// previous digit from ghosting, followed by ON_CYCLES lit cycles. One frame
// is NUM_DIGITS slots. A single hex-to-7-segment decoder is shared by all
// digits through a nibble mux indexed by the digit being scanned.
//
// New values arrive over a valid/ready handshake into a shadow register.
// The shadow is copied to the display register only at a frame boundary,
// so a frame never mixes old and new digits. While scanning is disabled,
// a pending value is copied on the next cycle, because there is no frame
// to tear.
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         synchronous, active-high reset
//   data_in     value to display, nibble [4i+3:4i] is digit i
//   load_valid  requester offers data_in
//   load_ready  controller can accept data_in (no value is pending)
//   blank_lz    blank leading zeros (digit 0 is always shown)
//   enable      1 = scan, 0 = display dark with the scanner parked
//   seg         segments a..g on seg[0]..seg[6], active-low, registered
//   an          digit anodes, an[i] drives digit i, active-low, registered
//   frame_tick  high during the last lit cycle of digit 3
// ============================================================================
module seg_scan_controller #(
    parameter int NUM_DIGITS  = 4,      // fixed at 4 in this revision
    parameter int ON_CYCLES   = 50000,  // lit cycles per digit slot, >= 1
    parameter int DEAD_CYCLES = 500     // dark cycles before each digit, >= 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic        blank_lz,
    input  logic        enable,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int MAX_CYCLES = (ON_CYCLES > DEAD_CYCLES) ? ON_CYCLES : DEAD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [1:0]       LAST_DIGIT = 2'(NUM_DIGITS - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef enum logic {
        DEAD = 1'b0,
        ON   = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Hex to 7-segment decode, active-low, bit order gfedcba
    // ------------------------------------------------------------------------
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        hex7 = SEG_BLANK;
        case (nib)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            4'hF: hex7 = 7'b0001110;
            default: hex7 = SEG_BLANK;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t           state, state_next;
    logic [1:0]       digit, digit_next;
    logic [CNT_W-1:0] cnt,   cnt_next;

    logic [15:0] display, display_next;
    logic [15:0] shadow,  shadow_next;
    logic        pending, pending_next;

    logic        commit;
    logic        xfer;

    logic [3:0]  nib_sel;
    logic [15:0] upper_digits;
    logic        blank_digit;
    logic [6:0]  glyph;
    logic        lit_next;
    logic [6:0]  seg_next;
    logic [3:0]  an_next;
    logic        tick_next;

    // ------------------------------------------------------------------------
    // Scan FSM: next state
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before any branch, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        digit_next = digit;
        cnt_next   = cnt + 1'b1;

        if (!enable) begin
            // Parked so that re-enabling always starts a fresh frame.
            state_next = DEAD;
            digit_next = 2'd0;
            cnt_next   = '0;
        end else begin
            case (state)
                DEAD: begin
                    if (cnt == DEAD_LAST) begin
                        state_next = ON;
                        cnt_next   = '0;
                    end
                end
                ON: begin
                    if (cnt == ON_LAST) begin
                        state_next = DEAD;
                        // A 2-bit index wraps from 3 back to 0 by itself.
                        digit_next = digit + 2'd1;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    state_next = DEAD;
                    digit_next = 2'd0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Load handshake and tear-free commit
    // ------------------------------------------------------------------------
    // frame_tick is the registered "last lit cycle of digit 3" flag, so a
    // commit lands on the edge that ends the frame. A value accepted on that
    // same edge was not pending yet, so it waits for the next boundary.
    always_comb begin
        commit       = pending && (frame_tick || !enable);
        xfer         = load_valid && load_ready;
        display_next = display;
        shadow_next  = shadow;
        pending_next = pending;

        if (commit) begin
            display_next = shadow;
            pending_next = 1'b0;
        end else if (xfer) begin
            shadow_next  = data_in;
            pending_next = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Output path: evaluated for the state being entered, so the registered
    // seg/an change on the same edge as the state and digit
    // ------------------------------------------------------------------------
    always_comb begin
        nib_sel      = display_next[{digit_next, 2'b00} +: 4];
        upper_digits = display_next >> {digit_next, 2'b00};
        // Digit i is a leading zero when it and every digit above it is zero.
        blank_digit  = blank_lz && (digit_next != 2'd0) && (upper_digits == 16'h0000);
        glyph        = hex7(nib_sel);

        lit_next  = (state_next == ON);
        seg_next  = (lit_next && !blank_digit) ? glyph : SEG_BLANK;
        an_next   = lit_next ? ~(4'b0001 << digit_next) : AN_OFF;
        tick_next = (state_next == ON) && (digit_next == LAST_DIGIT) && (cnt_next == ON_LAST);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DEAD;
            digit      <= 2'd0;
            cnt        <= '0;
            // NOTE: display and shadow are data registers, but they are reset
            // anyway because the display must show 0000 straight out of reset.
            display    <= 16'h0000;
            shadow     <= 16'h0000;
            pending    <= 1'b0;
            load_ready <= 1'b0;
            seg        <= SEG_BLANK;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_next;
            digit      <= digit_next;
            cnt        <= cnt_next;
            display    <= display_next;
            shadow     <= shadow_next;
            pending    <= pending_next;
            // Registered copy of !pending, held low during reset.
            load_ready <= !pending_next;
            seg        <= seg_next;
            an         <= an_next;
            frame_tick <= tick_next;
        end
    end

endmodule
